// File: rtl/lsu_bus_master.sv
// Memory-stage load/store unit: one req/ack data-bus transaction per access, with byte lanes
// and load extension. Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
module lsu_bus_master #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_m,
   input  logic              mem_write_m,
   input  logic [2:0]        dext_control_m,
   input  logic [ADDR_W-1:0] alu_result_m,
   input  logic [31:0]       write_data_m,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              stall_m,
   output logic [31:0]       read_data_m,
   output logic              load_valid,
   output logic              misalign_fault
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic [31:0]       r_bus_wdata;
   logic [1:0]        r_addr_lo;
   logic [2:0]        r_dext;
   logic [31:0]       r_read_data;
   logic              r_load_valid;

   logic              w_access;
   logic              w_misalign;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_ext;

   assign w_access = mem_read_m | mem_write_m;

`ifdef MISALIGN_TRAP_EN
   logic r_misalign_fault;

   always_comb begin
      w_misalign = 1'b0;
      case (dext_control_m[1:0])
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = alu_result_m[0];
         default: w_misalign = |alu_result_m[1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign_fault <= 1'b0;
      end else begin
         r_misalign_fault <= (r_state == StIdle) && w_access && w_misalign;
      end
   end

   assign misalign_fault = r_misalign_fault;
`else
   assign w_misalign     = 1'b0;
   assign misalign_fault = 1'b0;
`endif

   // Store lane placement; loads always fetch the whole word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = write_data_m;
      if (mem_write_m) begin
         case (dext_control_m[1:0])
            2'b00: begin
               w_be    = 4'b0001 << alu_result_m[1:0];
               w_wdata = {4{write_data_m[7:0]}};
            end
            2'b01: begin
               w_be    = alu_result_m[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{write_data_m[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (r_addr_lo)
         2'd1:    w_byte = bus_rdata[15:8];
         2'd2:    w_byte = bus_rdata[23:16];
         2'd3:    w_byte = bus_rdata[31:24];
         default: w_byte = bus_rdata[7:0];
      endcase
      w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (r_dext[1:0])
         2'b00:   w_load_ext = {{24{w_byte[7] & ~r_dext[2]}}, w_byte};
         2'b01:   w_load_ext = {{16{w_half[15] & ~r_dext[2]}}, w_half};
         default: w_load_ext = bus_rdata;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_access) w_state_next = w_misalign ? StDone : StReq;
         StReq:   if (bus_ack) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_be     <= 4'b0000;
         r_bus_wdata  <= 32'h0;
         r_addr_lo    <= 2'b00;
         r_dext       <= 3'b000;
         r_read_data  <= 32'h0;
         r_load_valid <= 1'b0;
      end else begin
         r_load_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_access && !w_misalign) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= mem_write_m;
                  r_bus_addr  <= {alu_result_m[ADDR_W-1:2], 2'b00};
                  r_bus_be    <= w_be;
                  r_bus_wdata <= w_wdata;
                  r_addr_lo   <= alu_result_m[1:0];
                  r_dext      <= dext_control_m;
               end
            end
            StReq: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  if (!r_bus_we) begin
                     r_read_data  <= w_load_ext;
                     r_load_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_m     = ~reset & (((r_state == StIdle) & w_access) | (r_state == StReq));
   assign bus_req     = r_bus_req;
   assign bus_we      = r_bus_we;
   assign bus_addr    = r_bus_addr;
   assign bus_be      = r_bus_be;
   assign bus_wdata   = r_bus_wdata;
   assign read_data_m = r_read_data;
   assign load_valid  = r_load_valid;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed vector table, reset/misalign sequences and
// randomized accesses against an arithmetic reference model.
module tb_lsu_bus_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_m, mem_write_m;
   logic [2:0]  dext_control_m;
   logic [31:0] alu_result_m, write_data_m;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, read_data_m;
   logic [3:0]  bus_be;
   logic        stall_m, load_valid, misalign_fault;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_rd = 32'h0;

   lsu_bus_master #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
      .dext_control_m(dext_control_m), .alu_result_m(alu_result_m),
      .write_data_m(write_data_m),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall_m(stall_m), .read_data_m(read_data_m), .load_valid(load_valid),
      .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] dx, input logic [31:0] a,
                                              input logic [31:0] rd);
      logic [31:0] v;
      if (dx[1:0] == 2'b00) begin
         v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
         if (!dx[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (dx[1:0] == 2'b01) begin
         v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
         if (!dx[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic wr, input logic [2:0] dx,
                                           input logic [31:0] a);
      if (!wr) return 4'hF;
      if (dx[1:0] == 2'b00) return 4'(1 << a[1:0]);
      if (dx[1:0] == 2'b01) return a[1] ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] dx, input logic [31:0] wd);
      if (dx[1:0] == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
      if (dx[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic bit model_trap(input logic [2:0] dx, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
      if (dx[1:0] == 2'b01) return a[0];
      if (dx[1:0] != 2'b00) return a[1:0] != 2'b00;
`endif
      return 1'b0;
   endfunction

   // One access from an idle DUT; bus acks after wait_n wait cycles.
   task automatic do_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] dx, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int wait_n,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wd, input logic [31:0] e_rd, input bit trap);
      int  stalls = 0, reqs = 0, lv = 0, mf = 0;
      bit  done = 0;
      bit  is_ld = rd && !wr;
      @(posedge clk); #1;
      mem_read_m = rd; mem_write_m = wr; dext_control_m = dx;
      alu_result_m = a; write_data_m = wd; bus_rdata = rdat; bus_ack = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (stall_m) stalls++;
         if (bus_req) begin
            check({nm, " bus_addr"}, bus_addr, e_addr);
            check({nm, " bus_be"}, {28'h0, bus_be}, {28'h0, e_be});
            check({nm, " bus_we"}, {31'h0, bus_we}, {31'h0, wr});
            if (wr) check({nm, " bus_wdata"}, bus_wdata, e_wd);
            bus_ack = (reqs == wait_n);
            reqs++;
         end else begin
            bus_ack = 1'b0;
         end
         if (load_valid) begin
            lv++;
            check({nm, " read_data_m"}, read_data_m, e_rd);
         end
         if (misalign_fault) mf++;
         if (!stall_m) begin
            done = 1;
            mem_read_m = 1'b0; mem_write_m = 1'b0;
         end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: actual=stall_m stuck required=release within 40 cycles", nm);
         mem_read_m = 1'b0; mem_write_m = 1'b0; bus_ack = 1'b0;
      end
      if (is_ld && !trap) last_rd = e_rd;
      check({nm, " stall cycles"}, stalls, trap ? 1 : 2 + wait_n);
      check({nm, " req cycles"}, reqs, trap ? 0 : wait_n + 1);
      check({nm, " load_valid pulses"}, lv, (is_ld && !trap) ? 1 : 0);
      check({nm, " misalign pulses"}, mf, trap ? 1 : 0);
      check({nm, " read_data_m held"}, read_data_m, last_rd);
   endtask

   typedef struct {
      string       nm;
      logic        rd, wr;
      logic [2:0]  dx;
      logic [31:0] a, wd, rdat;
      int          wait_n;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{"LW", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                  32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
      vecs[1] = '{"LB", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0,
                  32'h100, 4'hF, 32'h0, 32'hFFFFFF80};
      vecs[2] = '{"LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 0,
                  32'h100, 4'hF, 32'h0, 32'h00000080};
      vecs[3] = '{"SH", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3,
                  32'h100, 4'hC, 32'hABCDABCD, 32'h0};
      vecs[4] = '{"LH", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1,
                  32'h100, 4'hF, 32'h0, 32'hFFFF8001};
      vecs[5] = '{"LHU", 1, 0, 3'b101, 32'h100, 32'h0, 32'h80011234, 0,
                  32'h100, 4'hF, 32'h0, 32'h00001234};
      vecs[6] = '{"SB", 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 2,
                  32'h100, 4'h2, 32'hA5A5A5A5, 32'h0};
      vecs[7] = '{"SW", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0,
                  32'h204, 4'hF, 32'hCAFEF00D, 32'h0};
      vecs[8] = '{"LB+", 1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0,
                  32'h100, 4'hF, 32'h0, 32'h0000007F};
      vecs[9] = '{"RDWR", 1, 1, 3'b011, 32'h10C, 32'h87654321, 32'h0, 0,
                  32'h10C, 4'hF, 32'h87654321, 32'h0};

      reset = 1'b1; mem_read_m = 0; mem_write_m = 0; dext_control_m = 0;
      alu_result_m = 0; write_data_m = 0; bus_ack = 0; bus_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset bus_req", {31'h0, bus_req}, 32'h0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_be", {28'h0, bus_be}, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      check("reset read_data_m", read_data_m, 32'h0);
      check("reset pulses", {30'h0, load_valid, misalign_fault}, 32'h0);
      check("reset stall_m", {31'h0, stall_m}, 32'h0);
      reset = 1'b0;

      foreach (vecs[i])
         do_access(vecs[i].nm, vecs[i].rd, vecs[i].wr, vecs[i].dx, vecs[i].a, vecs[i].wd,
                   vecs[i].rdat, vecs[i].wait_n, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wd,
                   vecs[i].e_rd, 1'b0);

      // Misaligned word load: trapped or treated as the aligned word.
`ifdef MISALIGN_TRAP_EN
      do_access("LW mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0,
                32'h100, 4'hF, 32'h0, 32'h0, 1'b1);
`else
      do_access("LW mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0,
                32'h100, 4'hF, 32'h0, 32'h11223344, 1'b0);
`endif

      // Reset in REQ with the ack withheld; a later ack must be ignored.
      @(posedge clk); #1;
      mem_read_m = 1; dext_control_m = 3'b010; alu_result_m = 32'h300; bus_rdata = 32'h5A5A5A5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre-reset bus_req", {31'h0, bus_req}, 32'h1);
      reset = 1'b1;
      #1 check("stall_m during reset", {31'h0, stall_m}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; mem_read_m = 0;
      @(negedge clk);
      check("post-reset bus_req", {31'h0, bus_req}, 32'h0);
      check("post-reset bus_addr", bus_addr, 32'h0);
      check("post-reset read_data_m", read_data_m, 32'h0);
      check("post-reset stall_m", {31'h0, stall_m}, 32'h0);
      bus_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("late ack ignored", {30'h0, bus_req, load_valid}, 32'h0);
      end
      bus_ack = 1'b0;
      last_rd = 32'h0;

      // Randomized accesses against the model.
      for (int k = 0; k < 150; k++) begin
         logic        rd, wr;
         logic [2:0]  dx;
         logic [31:0] a, wd, rdat;
         int          w;
         bit          trap;
         wr   = 1'($urandom_range(0, 1));
         rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         dx   = 3'($urandom);
         a    = {20'h0, 12'($urandom)};
         wd   = $urandom;
         rdat = $urandom;
         w    = $urandom_range(0, 3);
         trap = model_trap(dx, a);
         do_access("rand", rd, wr, dx, a, wd, rdat, w, {a[31:2], 2'b00}, model_be(wr, dx, a),
                   model_wd(dx, wd), model_load(dx, a, rdat), trap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
